deserializer: RTL and testbench

- Consumes the serial stream produced by the serializer (one bit per clock, MSB first, qualified by a valid strobe) and rebuilds parallel words.
- Emits one parallel word per burst, plus a bit-count modifier, with the same encoding the serializer accepts: 0 = full width, otherwise number of valid MSBs.
- Sits directly downstream of the serializer on the same clock.

---
 rtl/serdes_pkg.sv | 13 +
 rtl/deserializer.sv | 90 +++++++++
 tb/tb_deserializer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/serdes_pkg.sv
// Definitions shared by the serializer and deserializer: the FSM state encoding and
// the shortest burst either side will accept.
package serdes_pkg;

  typedef enum logic [1:0] {
    IDLE_S = 2'd1,
    RECV_S = 2'd2,
    X      = 'x
  } state_t;

  localparam int unsigned MIN_BURST_LEN = 3;

endpackage

// File: rtl/deserializer.sv
// Rebuilds MSB-first serial bursts into MSB-aligned parallel words with a bit-count modifier.
// Optional DESERIALIZER_RUNT_ERR_EN adds runt_err_o, pulsing when a 1- or 2-bit burst is dropped.
module deserializer
  import serdes_pkg::*;
#(
  parameter int unsigned DATA_BUS_WIDTH = 16,
  parameter int unsigned DATA_MOD_WIDTH = $clog2(DATA_BUS_WIDTH)
) (
  input  logic                      clk_i,
  input  logic                      srst_i,
`ifdef DESERIALIZER_RUNT_ERR_EN
  output logic                      runt_err_o,
`endif
  input  logic                      data_i,
  input  logic                      data_val_i,
  output logic [DATA_BUS_WIDTH-1:0] deser_data_o,
  output logic [DATA_MOD_WIDTH-1:0] deser_data_mod_o,
  output logic                      deser_data_val_o
);

  localparam int unsigned CNT_W = DATA_MOD_WIDTH + 1;

  state_t                    state;
  logic [CNT_W-1:0]          cnt;
  logic [DATA_BUS_WIDTH-1:0] shift_q;
  logic [CNT_W-1:0]          bit_idx_c;

  // Bit k of the burst lands at position DATA_BUS_WIDTH-1-k.
  assign bit_idx_c = CNT_W'(DATA_BUS_WIDTH - 1) - cnt;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state            <= IDLE_S;
      cnt              <= '0;
      shift_q          <= '0;
      deser_data_o     <= '0;
      deser_data_mod_o <= '0;
      deser_data_val_o <= 1'b0;
`ifdef DESERIALIZER_RUNT_ERR_EN
      runt_err_o       <= 1'b0;
`endif
    end else begin
      deser_data_val_o <= 1'b0;
`ifdef DESERIALIZER_RUNT_ERR_EN
      runt_err_o       <= 1'b0;
`endif
      case (state)
        IDLE_S: begin
          if (data_val_i) begin
            shift_q <= {data_i, {(DATA_BUS_WIDTH-1){1'b0}}};
            cnt     <= CNT_W'(1);
            state   <= RECV_S;
          end
        end
        RECV_S: begin
          if (data_val_i) begin
            if (cnt == CNT_W'(DATA_BUS_WIDTH - 1)) begin
              // Last bit goes straight to the output so a following bit can start a new word.
              deser_data_o     <= {shift_q[DATA_BUS_WIDTH-1:1], data_i};
              deser_data_mod_o <= '0;
              deser_data_val_o <= 1'b1;
              cnt              <= '0;
              state            <= IDLE_S;
            end else begin
              shift_q[bit_idx_c[DATA_MOD_WIDTH-1:0]] <= data_i;
              cnt                                    <= cnt + CNT_W'(1);
            end
          end else begin
            if (cnt >= CNT_W'(MIN_BURST_LEN)) begin
              deser_data_o     <= shift_q;
              deser_data_mod_o <= DATA_MOD_WIDTH'(cnt);
              deser_data_val_o <= 1'b1;
            end else begin
`ifdef DESERIALIZER_RUNT_ERR_EN
              runt_err_o <= 1'b1;
`endif
            end
            cnt   <= '0;
            state <= IDLE_S;
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE_S;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// Self-checking bench for deserializer: table-driven bursts plus hand-written corner sequences.
module tb_deserializer;

  localparam int unsigned W  = 16;
  localparam int unsigned MW = 4;

  logic          clk_i = 1'b0;
  logic          srst_i;
  logic          data_i;
  logic          data_val_i;
  logic [W-1:0]  deser_data_o;
  logic [MW-1:0] deser_data_mod_o;
  logic          deser_data_val_o;
`ifdef DESERIALIZER_RUNT_ERR_EN
  logic          runt_err_o;
`endif

  always #5 clk_i = ~clk_i;

  deserializer #(.DATA_BUS_WIDTH(W), .DATA_MOD_WIDTH(MW)) dut (
    .clk_i            (clk_i),
    .srst_i           (srst_i),
`ifdef DESERIALIZER_RUNT_ERR_EN
    .runt_err_o       (runt_err_o),
`endif
    .data_i           (data_i),
    .data_val_i       (data_val_i),
    .deser_data_o     (deser_data_o),
    .deser_data_mod_o (deser_data_mod_o),
    .deser_data_val_o (deser_data_val_o)
  );

  typedef struct packed {
    logic [W-1:0]  d;
    logic [MW-1:0] m;
  } exp_t;

  typedef struct {
    logic [W-1:0] word;
    int           len;
  } vec_t;

  exp_t sb_q[$];
  exp_t model_hold;
  int   pulse_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   pulses_exp = 0;
  int   runt_exp = 0;
  int   runt_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk_i) cyc++;

  // Scoreboard consumer: every pulse must match the oldest pending expectation.
  always @(negedge clk_i) begin
    if (deser_data_val_o === 1'b1) begin
      pulse_cyc.push_back(cyc);
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("pulse_data", 32'(deser_data_o), 32'(e.d));
        check("pulse_mod", 32'(deser_data_mod_o), 32'(e.m));
      end
    end
`ifdef DESERIALIZER_RUNT_ERR_EN
    if (runt_err_o === 1'b1) runt_seen++;
`endif
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Drive len bits of word MSB first; optionally end with a low-valid cycle.
  task automatic send_burst(input logic [W-1:0] word, input int len, input bit terminate);
    exp_t e;
    e.d = word & ~({W{1'b1}} >> len);
    e.m = (len == int'(W)) ? '0 : MW'(len);
    if (len == int'(W) || (terminate && len >= 3)) begin
      sb_q.push_back(e);
      model_hold = e;
      pulses_exp++;
    end else if (terminate) begin
      runt_exp++;
    end
    for (int i = 0; i < len; i++) begin
      data_i     = word[W-1-i];
      data_val_i = 1'b1;
      tick();
    end
    if (terminate) begin
      data_val_i = 1'b0;
      data_i     = 1'($urandom);
      tick();
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      data_val_i = 1'b0;
      data_i     = 1'($urandom);
      tick();
    end
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{16'hA5C3, 16};
    vecs[1] = '{16'hB000, 5};
    vecs[2] = '{16'hC000, 2};
    vecs[3] = '{16'h8000, 1};
    vecs[4] = '{16'hE000, 3};
    vecs[5] = '{16'h5A5B, 15};
    vecs[6] = '{16'h0001, 16};
    vecs[7] = '{16'hFFFF, 4};

    srst_i     = 1'b1;
    data_i     = 1'b0;
    data_val_i = 1'b0;
    model_hold = '0;
    repeat (3) tick();
    srst_i = 1'b0;
    check("reset_data", 32'(deser_data_o), 32'd0);
    check("reset_mod", 32'(deser_data_mod_o), 32'd0);
    check("reset_val", 32'(deser_data_val_o), 32'd0);
    idle(2);

    foreach (vecs[i]) begin
      send_burst(vecs[i].word, vecs[i].len, 1'b1);
      idle(2);
      check("hold_data", 32'(deser_data_o), 32'(model_hold.d));
      check("hold_mod", 32'(deser_data_mod_o), 32'(model_hold.m));
      check("hold_val_low", 32'(deser_data_val_o), 32'd0);
    end

    // Back-to-back full words with valid held high throughout.
    begin
      int n0;
      n0 = pulse_cyc.size();
      send_burst(16'h1234, 16, 1'b0);
      send_burst(16'hFFFF, 16, 1'b1);
      idle(2);
      if (pulse_cyc.size() >= n0 + 2)
        check("b2b_spacing", 32'(pulse_cyc[n0+1] - pulse_cyc[n0]), 32'd16);
      else
        check("b2b_pulse_count", 32'(pulse_cyc.size() - n0), 32'd2);
    end

    // Reset mid-burst discards the partial word and clears the outputs.
    for (int i = 0; i < 9; i++) begin
      data_i     = 1'($urandom);
      data_val_i = 1'b1;
      tick();
    end
    srst_i     = 1'b1;
    data_val_i = 1'b0;
    tick();
    srst_i     = 1'b0;
    model_hold = '0;
    check("midrst_data", 32'(deser_data_o), 32'd0);
    check("midrst_mod", 32'(deser_data_mod_o), 32'd0);
    send_burst(16'h0F0F, 16, 1'b1);
    idle(2);

    // Serializer-style stream for data 0xBEEF with mod 7.
    send_burst(16'hBEEF, 7, 1'b1);
    idle(2);
    check("loopback_data", 32'(deser_data_o), 32'h0000_BE00);
    check("loopback_mod", 32'(deser_data_mod_o), 32'd7);

    idle(4);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    check("pulse_total", 32'(pulse_cyc.size()), 32'(pulses_exp));
`ifdef DESERIALIZER_RUNT_ERR_EN
    check("runt_pulses", 32'(runt_seen), 32'(runt_exp));
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
